reg_dump_reader: RTL and testbench

Debug read-out engine that sits on the read side of the 32×32 register unit. On a start pulse it walks x0..x31 through a dedicated asynchronous read port, captures each word and streams the full register file as a byte frame over a valid/ready interface. Typical sinks are a UART transmitter or a trace FIFO. It lets the bench or a debug host dump architectural state without touching the datapath.

---
 rtl/reg_dump_reader.sv | 135 +++++++++++++
 tb/tb_reg_dump_reader.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - streams a snapshot of the register file as a byte frame
module reg_dump_reader #(
    parameter int         NUM_REGS = 32,
    parameter int         ADDR_W   = 5,
    parameter int         DATA_W   = 32,
    parameter logic [7:0] HDR      = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        SEND,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [BC_W-1:0]   byte_cnt, byte_cnt_n;
    logic [DATA_W-1:0] word, word_n;
    logic [DATA_W-1:0] word_shr;
    logic [7:0]        tx_data_n;
    logic              tx_valid_n;
    logic              busy_n;
    logic              done_n;

    // The captured word is consumed by shifting, so the next byte is always at [15:8].
    assign word_shr = word >> 8;
    assign rf_addr  = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            byte_cnt <= '0;
            word     <= '0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            byte_cnt <= byte_cnt_n;
            word     <= word_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        byte_cnt_n = byte_cnt;
        word_n     = word;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        busy_n     = busy;
        done_n     = 1'b0;

        unique case (state)
            IDLE: begin
                busy_n     = 1'b0;
                tx_valid_n = 1'b0;
                if (start) begin
                    state_n    = HEADER;
                    tx_data_n  = HDR;
                    tx_valid_n = 1'b1;
                    idx_n      = '0;
                    byte_cnt_n = '0;
                    busy_n     = 1'b1;
                end
            end
            HEADER: begin
                if (tx_ready) begin
                    state_n    = LOAD;
                    tx_valid_n = 1'b0;
                end
            end
            LOAD: begin
                // rf_addr has been stable since the previous edge; this edge is the snapshot point.
                word_n     = rf_data;
                tx_data_n  = rf_data[7:0];
                tx_valid_n = 1'b1;
                state_n    = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    if (byte_cnt != LAST_BYTE) begin
                        byte_cnt_n = byte_cnt + 1'b1;
                        word_n     = word_shr;
                        tx_data_n  = word_shr[7:0];
                    end else if (idx == LAST_IDX) begin
                        state_n    = DONE;
                        tx_valid_n = 1'b0;
                        done_n     = 1'b1;
                    end else begin
                        idx_n      = idx + 1'b1;
                        byte_cnt_n = '0;
                        tx_valid_n = 1'b0;
                        state_n    = LOAD;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n    = IDLE;
                busy_n     = 1'b0;
                tx_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized self-checking bench for reg_dump_reader
module tb_reg_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] regs [32];
    logic [7:0]  got [$];
    int          got_t [$];
    logic [7:0]  exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int e0 = 0;
    int done_cnt = 0;
    int done_t = -1;
    int last_busy_t = -1;
    int stall_cnt = 0;
    int mode = 0;
    int hold_cnt = 0;
    bit hold_done = 0;
    bit prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    bit          wr_pend = 0;
    int          wr_rel = 0;
    int          wr_idx = 0;
    logic [31:0] wr_val = 0;

    reg_dump_reader #(
        .NUM_REGS(32),
        .ADDR_W  (5),
        .DATA_W  (32),
        .HDR     (8'hA5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    // Register unit model: asynchronous read, x0 hardwired to zero.
    assign rf_data = (rf_addr == 5'd0) ? 32'd0 : regs[rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Observer: runs on the falling edge, labels everything relative to the start edge.
    always @(negedge clk) begin
        int rel;
        rel = cyc + 1 - e0;
        if (rst_n) begin
            if (prev_stall) begin
                check_eq("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
                check_eq("hold_valid", {31'd0, tx_valid}, 32'd1);
            end
            if (tx_valid && tx_ready) begin
                got.push_back(tx_data);
                got_t.push_back(rel);
            end
            if (tx_valid && !tx_ready) stall_cnt++;
            if (done) begin
                done_cnt++;
                done_t = rel;
            end
            if (busy) last_busy_t = rel;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (wr_pend && rel == wr_rel) begin
                regs[wr_idx] = wr_val;
                wr_pend = 0;
            end
        end else begin
            prev_stall = 0;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (mode == 0) begin
            tx_ready = 1'b1;
        end else if (hold_cnt > 0) begin
            tx_ready = 1'b0;
            hold_cnt--;
        end else if (!hold_done && got.size() >= 31) begin
            tx_ready  = 1'b0;
            hold_cnt  = 9;
            hold_done = 1;
        end else begin
            tx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic preload();
        regs[0] = $urandom;
        for (int k = 1; k < 32; k++) regs[k] = 32'h03020100 + 32'h04040404 * k;
    endtask

    task automatic build_exp();
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 32; k++) begin
            w = (k == 0) ? 32'd0 : regs[k];
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic start_frame();
        got.delete();
        got_t.delete();
        done_cnt  = 0;
        stall_cnt = 0;
        hold_done = 0;
        hold_cnt  = 0;
        e0    = cyc + 1;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int want, input int limit);
        int n;
        n = 0;
        while (done_cnt < want && n < limit) begin
            cycle();
            n++;
        end
        check_eq(tag, done_cnt >= want, 1);
    endtask

    task automatic check_stream(input string tag, input int base, input int total);
        int bad;
        bad = 0;
        check_eq({tag, "_len"}, got.size(), total);
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i >= got.size() || got[base + i] !== exp_q[i]) bad++;
        check_eq({tag, "_bytes_bad"}, bad, 0);
    endtask

    function automatic logic [31:0] got_word(input int k);
        return {got[4*k + 4], got[4*k + 3], got[4*k + 2], got[4*k + 1]};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] old5;
        int bad;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        tx_ready = 1'b0;
        for (int k = 0; k < 32; k++) regs[k] = $urandom;

        // Reset with random inputs
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            start    = 1'($urandom_range(0, 1));
            tx_ready = 1'($urandom_range(0, 1));
            regs[$urandom_range(1, 31)] = $urandom;
        end
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_done", {31'd0, done}, 0);
        check_eq("rst_valid", {31'd0, tx_valid}, 0);
        check_eq("rst_data", {24'd0, tx_data}, 0);
        check_eq("rst_addr", {27'd0, rf_addr}, 0);
        start = 1'b0;
        rst_n = 1'b1;
        cycle();
        cycle();

        // Full dump, no backpressure
        preload();
        mode = 0;
        build_exp();
        start_frame();
        wait_done("full_timeout", 1, 400);
        repeat (4) cycle();
        check_stream("full", 0, 129);
        check_eq("full_done_t", done_t, 162);
        check_eq("full_busy_end", last_busy_t, 162);
        check_eq("full_done_cnt", done_cnt, 1);
        check_eq("full_hdr_t", got_t.size() > 0 ? got_t[0] : -1, 1);
        bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (i == 0 && got[i] != 8'hA5) bad++;
            if (i >= 1 && i <= 4 && got[i] != 8'h00) bad++;
            if (i >= 5 && got[i] != 8'(i - 1)) bad++;
        end
        check_eq("full_pattern_bad", bad, 0);

        // Random backpressure with a long hold inside x7
        mode = 1;
        build_exp();
        start_frame();
        wait_done("bp_timeout", 1, 2000);
        mode = 0;
        repeat (4) cycle();
        check_stream("bp", 0, 129);
        check_eq("bp_done_t", done_t, 162 + stall_cnt);
        check_eq("bp_hold_seen", {31'd0, hold_done}, 1);

        // start pulses in HEADER, LOAD, SEND, DONE are ignored; one at cycle 163 is accepted
        build_exp();
        start_frame();
        n = cyc + 1 - e0;
        while (n <= 170) begin
            start = (n == 1 || n == 2 || n == 3 || n == 162 || n == 163);
            cycle();
            n = cyc + 1 - e0;
        end
        start = 1'b0;
        check_eq("st_one_done", done_cnt, 1);
        check_eq("st_second_hdr", got.size() > 129 ? {24'd0, got[129]} : 32'hFFFF, 32'hA5);
        check_eq("st_second_hdr_t", got_t.size() > 129 ? got_t[129] : -1, 164);
        wait_done("st_timeout", 2, 400);
        repeat (4) cycle();
        check_eq("st_second_done_t", done_t, 325);
        check_stream("st_first", 0, 258);
        check_stream("st_second", 129, 258);

        // Write to x5 on the negedge before its LOAD edge is captured
        preload();
        old5 = regs[5];
        regs[5] = 32'hDEADBEEF;
        build_exp();
        regs[5] = old5;
        wr_idx = 5; wr_val = 32'hDEADBEEF; wr_rel = 27; wr_pend = 1;
        start_frame();
        wait_done("snap_pre_timeout", 1, 400);
        repeat (3) cycle();
        check_eq("snap_pre_applied", {31'd0, wr_pend}, 0);
        check_stream("snap_pre", 0, 129);
        check_eq("snap_pre_x5", got.size() >= 129 ? got_word(5) : 32'h0, 32'hDEADBEEF);

        // Same write one negedge later is missed
        regs[5] = old5;
        build_exp();
        wr_idx = 5; wr_val = 32'hDEADBEEF; wr_rel = 28; wr_pend = 1;
        start_frame();
        wait_done("snap_post_timeout", 1, 400);
        repeat (3) cycle();
        check_eq("snap_post_applied", {31'd0, wr_pend}, 0);
        check_stream("snap_post", 0, 129);
        check_eq("snap_post_x5", got.size() >= 129 ? got_word(5) : 32'h0, old5);

        // Writes to x0 never show
        build_exp();
        wr_idx = 0; wr_val = $urandom | 32'h1; wr_rel = 1; wr_pend = 1;
        start_frame();
        wait_done("x0_timeout", 1, 400);
        repeat (3) cycle();
        check_eq("x0_word", got.size() >= 129 ? got_word(0) : 32'hFFFF_FFFF, 0);

        // Asynchronous reset after 50 bytes, then a fresh frame
        preload();
        build_exp();
        start_frame();
        n = 0;
        while (!(got.size() >= 50 && tx_valid) && n < 300) begin
            cycle();
            n++;
        end
        check_eq("mid_reached", got.size() >= 50, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_valid", {31'd0, tx_valid}, 0);
        check_eq("async_busy", {31'd0, busy}, 0);
        check_eq("async_data", {24'd0, tx_data}, 0);
        cycle();
        cycle();
        got.delete();
        got_t.delete();
        rst_n = 1'b1;
        repeat (10) cycle();
        check_eq("no_residual", got.size(), 0);
        start_frame();
        wait_done("after_rst_timeout", 1, 400);
        repeat (3) cycle();
        check_stream("after_rst", 0, 129);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
